// File: rtl/hazard_unit_pkg.sv
// Shared constants and types for the pipeline hazard controller:
// EX forwarding select encodings and the hazard FSM state type.
package hazard_unit_pkg;

  localparam int REG_AW_DEF = 4;
  localparam int CNT_W      = 2;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_LOAD_STALL = 2'b01,
    ST_JUMP_FLUSH = 2'b10
  } hz_state_t;

endpackage

// File: rtl/hazard_unit_if.sv
// Decode-stage strobes from the control unit and stall/flush/forward
// controls back to the datapath, bundled as one port.
interface hazard_unit_if #(
  parameter int REG_AW = 4
);
  logic              i_validD;
  logic [REG_AW-1:0] i_rs1D;
  logic [REG_AW-1:0] i_rs2D;
  logic [REG_AW-1:0] i_rdD;
  logic              i_RegWriteD;
  logic              i_MemReadD;
  logic              i_jumpD;
  logic              i_flushD;
  logic              o_stallF;
  logic              o_stallD;
  logic              o_flushD;
  logic              o_flushE;
  logic [1:0]        o_fwdA;
  logic [1:0]        o_fwdB;

  modport master (
    output i_validD, i_rs1D, i_rs2D, i_rdD, i_RegWriteD, i_MemReadD, i_jumpD, i_flushD,
    input  o_stallF, o_stallD, o_flushD, o_flushE, o_fwdA, o_fwdB
  );

  modport slave (
    input  i_validD, i_rs1D, i_rs2D, i_rdD, i_RegWriteD, i_MemReadD, i_jumpD, i_flushD,
    output o_stallF, o_stallD, o_flushD, o_flushE, o_fwdA, o_fwdB
  );
endinterface

// File: rtl/hazard_unit_fwd_select.sv
// EX-operand forwarding select: compares one E-stage source against the
// M and W destinations; M is younger and therefore wins.
module fwd_select
  import hazard_unit_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic [REG_AW-1:0] i_rsE,
  input  logic              i_vldM,
  input  logic              i_regwrM,
  input  logic [REG_AW-1:0] i_rdM,
  input  logic              i_vldW,
  input  logic              i_regwrW,
  input  logic [REG_AW-1:0] i_rdW,
  output logic [1:0]        o_fwd
);

  logic w_src_nz;
  logic w_hitM;
  logic w_hitW;

  // R0 reads are constant zero, so a zero source never takes a bypass.
  assign w_src_nz = (i_rsE != '0);
  assign w_hitM   = i_vldM & i_regwrM & (i_rdM == i_rsE) & w_src_nz;
  assign w_hitW   = i_vldW & i_regwrW & (i_rdW == i_rsE) & w_src_nz;

  always_comb begin
    o_fwd = FWD_RF;
    if (w_hitM)      o_fwd = FWD_MEM;
    else if (w_hitW) o_fwd = FWD_WB;
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller for the D/E/M/W pipeline: shadows in-flight destinations,
// drives EX forwarding, inserts load-use stalls and sequences jump flushes.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int REG_AW       = REG_AW_DEF,
  parameter int JUMP_PENALTY = 1
) (
  input  logic        clk,
  input  logic        reset,
  hazard_unit_if.slave io_hz
);

  localparam logic [CNT_W-1:0] PENALTY = CNT_W'(JUMP_PENALTY);

  // Shadow pipe: _p0 = E, _p1 = M, _p2 = W. M/W keep only what forwarding needs.
  logic              r_vld_p0, r_vld_p1, r_vld_p2;
  logic [REG_AW-1:0] r_rd_p0, r_rd_p1, r_rd_p2;
  logic              r_rw_p0, r_rw_p1, r_rw_p2;
  logic              r_mr_p0;
  logic [REG_AW-1:0] r_rs1_p0, r_rs2_p0;

  hz_state_t         r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_flush_fsm;

  logic              w_hit;
  logic              w_stall;
  logic [1:0]        w_fwdA;
  logic [1:0]        w_fwdB;

  assign w_hit = io_hz.i_validD & r_vld_p0 & r_mr_p0 & (r_rd_p0 != '0) &
                 ((r_rd_p0 == io_hz.i_rs1D) | (r_rd_p0 == io_hz.i_rs2D));

  // ---- D -> E -> M -> W : valid bits (control, reset) ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      r_vld_p0 <= io_hz.i_validD & ~w_hit;
      r_vld_p1 <= r_vld_p0;
      r_vld_p2 <= r_vld_p1;
    end
  end

  // ---- D -> E -> M -> W : entry fields, qualified by the valid bits ----
  always_ff @(posedge clk) begin
    r_rd_p0  <= io_hz.i_rdD;
    r_rw_p0  <= io_hz.i_RegWriteD;
    r_mr_p0  <= io_hz.i_MemReadD;
    r_rs1_p0 <= io_hz.i_rs1D;
    r_rs2_p0 <= io_hz.i_rs2D;
    r_rd_p1  <= r_rd_p0;
    r_rw_p1  <= r_rw_p0;
    r_rd_p2  <= r_rd_p1;
    r_rw_p2  <= r_rw_p1;
  end

  // A jump still sitting in D after a load-use stall is taken from LOAD_STALL.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_flush_fsm <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_LOAD_STALL: begin
          if (w_hit) begin
            r_state     <= ST_LOAD_STALL;
            r_flush_fsm <= 1'b0;
          end else if (io_hz.i_validD & io_hz.i_jumpD) begin
            r_state     <= ST_JUMP_FLUSH;
            r_cnt       <= PENALTY;
            r_flush_fsm <= 1'b1;
          end else begin
            r_state     <= ST_IDLE;
            r_flush_fsm <= 1'b0;
          end
        end
        ST_JUMP_FLUSH: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt <= CNT_W'(1)) begin
            r_state     <= ST_IDLE;
            r_flush_fsm <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cnt       <= '0;
          r_flush_fsm <= 1'b0;
        end
      endcase
    end
  end

  fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
    .i_rsE   (r_rs1_p0),
    .i_vldM  (r_vld_p1),
    .i_regwrM(r_rw_p1),
    .i_rdM   (r_rd_p1),
    .i_vldW  (r_vld_p2),
    .i_regwrW(r_rw_p2),
    .i_rdW   (r_rd_p2),
    .o_fwd   (w_fwdA)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
    .i_rsE   (r_rs2_p0),
    .i_vldM  (r_vld_p1),
    .i_regwrM(r_rw_p1),
    .i_rdM   (r_rd_p1),
    .i_vldW  (r_vld_p2),
    .i_regwrW(r_rw_p2),
    .i_rdW   (r_rd_p2),
    .o_fwd   (w_fwdB)
  );

  // Stall outranks any flush of IF/ID; reset forces every control low.
  assign w_stall        = ~reset & w_hit;
  assign io_hz.o_stallF = w_stall;
  assign io_hz.o_stallD = w_stall;
  assign io_hz.o_flushE = w_stall;
  assign io_hz.o_flushD = ~reset & ~w_hit & (r_flush_fsm | io_hz.i_flushD);
  assign io_hz.o_fwdA   = reset ? FWD_RF : w_fwdA;
  assign io_hz.o_fwdB   = reset ? FWD_RF : w_fwdB;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed pipeline scenarios, then random decode
// traffic, all compared against a queue-style pipeline reference model.
module tb_hazard_unit;
  import hazard_unit_pkg::*;

  localparam int AW  = 4;
  localparam int PEN = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_unit_if #(.REG_AW(AW)) hz ();

  hazard_unit #(.REG_AW(AW), .JUMP_PENALTY(PEN)) dut (
    .clk  (clk),
    .reset(reset),
    .io_hz(hz)
  );

  typedef struct {
    bit v;
    bit rw;
    bit mr;
    int rd;
    int rs1;
    int rs2;
  } ent_t;

  ent_t pipe [3];      // 0 = E, 1 = M, 2 = W
  int   flush_left;    // IF/ID flush cycles still owed to a jump
  bit   exp_stall;
  int   checks = 0;
  int   errors = 0;

  logic       obs_sf, obs_sd, obs_fd, obs_fe;
  logic [1:0] obs_fa, obs_fb;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int fwd_of(input int src);
    if (src == 0) return 0;
    if (pipe[1].v && pipe[1].rw && pipe[1].rd == src) return 1;
    if (pipe[2].v && pipe[2].rw && pipe[2].rd == src) return 2;
    return 0;
  endfunction

  task automatic drv(input bit v, input int rs1, input int rs2, input int rd,
                     input bit rw, input bit mr, input bit j, input bit fl);
    hz.i_validD    = v;
    hz.i_rs1D      = AW'(rs1);
    hz.i_rs2D      = AW'(rs2);
    hz.i_rdD       = AW'(rd);
    hz.i_RegWriteD = rw;
    hz.i_MemReadD  = mr;
    hz.i_jumpD     = j;
    hz.i_flushD    = fl;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One clock: predict, sample at negedge, then advance the model at posedge.
  task automatic do_cycle(input string tag);
    bit   hit, efd, fwd_known;
    int   efa, efb, rs1, rs2;
    ent_t nxt;
    rs1 = int'(hz.i_rs1D);
    rs2 = int'(hz.i_rs2D);
    hit = !reset && hz.i_validD && pipe[0].v && pipe[0].mr && pipe[0].rd != 0 &&
          (pipe[0].rd == rs1 || pipe[0].rd == rs2);
    efd = !reset && !hit && (flush_left > 0 || hz.i_flushD);
    efa = reset ? 0 : fwd_of(pipe[0].rs1);
    efb = reset ? 0 : fwd_of(pipe[0].rs2);
    fwd_known = reset || pipe[0].v || (!pipe[1].v && !pipe[2].v);
    @(negedge clk);
    obs_sf = hz.o_stallF; obs_sd = hz.o_stallD; obs_fd = hz.o_flushD;
    obs_fe = hz.o_flushE; obs_fa = hz.o_fwdA;   obs_fb = hz.o_fwdB;
    chk({tag, ".stallF"}, 8'(obs_sf), 8'(hit));
    chk({tag, ".stallD"}, 8'(obs_sd), 8'(hit));
    chk({tag, ".flushE"}, 8'(obs_fe), 8'(hit));
    chk({tag, ".flushD"}, 8'(obs_fd), 8'(efd));
    if (fwd_known) begin
      chk({tag, ".fwdA"}, 8'(obs_fa), 8'(efa));
      chk({tag, ".fwdB"}, 8'(obs_fb), 8'(efb));
    end
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 3; i++) pipe[i].v = 1'b0;
      flush_left = 0;
      exp_stall  = 1'b0;
    end else begin
      nxt.v   = hz.i_validD && !hit;
      nxt.rw  = hz.i_RegWriteD;
      nxt.mr  = hz.i_MemReadD;
      nxt.rd  = int'(hz.i_rdD);
      nxt.rs1 = rs1;
      nxt.rs2 = rs2;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = nxt;
      if (flush_left > 0) flush_left--;
      else if (hz.i_validD && hz.i_jumpD && !hit) flush_left = PEN;
      exp_stall = hit;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) pipe[i] = '{v: 0, rw: 0, mr: 0, rd: 0, rs1: 0, rs2: 0};
    flush_left = 0;
    exp_stall  = 1'b0;
    reset = 1'b1;
    idle();
    #1;
    do_cycle("reset0");
    do_cycle("reset1");
    chk("reset.flushD", 8'(obs_fd), 8'd0);
    chk("reset.fwdA", 8'(obs_fa), 8'd0);
    reset = 1'b0;

    // Back-to-back ADD r3 ; ADD r4,r3 -> bypass from M
    drv(1, 0, 0, 3, 1, 0, 0, 0); do_cycle("addA");
    drv(1, 3, 0, 4, 1, 0, 0, 0); do_cycle("addB");
    idle();                      do_cycle("addE");
    chk("b2b.fwdA_mem", 8'(obs_fa), 8'd1);
    do_cycle("drain"); do_cycle("drain");

    // One gap between producer and consumer -> bypass from W
    drv(1, 0, 0, 3, 1, 0, 0, 0); do_cycle("gapA");
    idle();                      do_cycle("gapBub");
    drv(1, 3, 0, 4, 1, 0, 0, 0); do_cycle("gapB");
    idle();                      do_cycle("gapE");
    chk("gap.fwdA_wb", 8'(obs_fa), 8'd2);
    do_cycle("drain"); do_cycle("drain");

    // r3 in both M and W -> M wins on operand B
    drv(1, 0, 0, 3, 1, 0, 0, 0); do_cycle("prioW");
    drv(1, 0, 0, 3, 1, 0, 0, 0); do_cycle("prioM");
    drv(1, 0, 3, 7, 1, 0, 0, 0); do_cycle("prioC");
    idle();                      do_cycle("prioE");
    chk("prio.fwdB_mem", 8'(obs_fb), 8'd1);
    chk("prio.fwdA_rf", 8'(obs_fa), 8'd0);
    // Write to r0 in M never forwards
    drv(1, 0, 0, 0, 1, 0, 0, 0); do_cycle("r0W");
    drv(1, 0, 0, 8, 1, 0, 0, 0); do_cycle("r0C");
    idle();                      do_cycle("r0E");
    chk("r0.fwdB_rf", 8'(obs_fb), 8'd0);
    do_cycle("drain"); do_cycle("drain");

    // LOAD r5 ; ADD r6,r5 -> one stall, then bypass from W
    drv(1, 0, 0, 5, 1, 1, 0, 0); do_cycle("ldA");
    drv(1, 5, 0, 6, 1, 0, 0, 0); do_cycle("ldHit");
    chk("ld.stallF", 8'(obs_sf), 8'd1);
    chk("ld.stallD", 8'(obs_sd), 8'd1);
    chk("ld.flushE", 8'(obs_fe), 8'd1);
    do_cycle("ldRel");
    chk("ld.stall_once", 8'(obs_sf), 8'd0);
    idle();                      do_cycle("ldE");
    chk("ld.fwdA_wb", 8'(obs_fa), 8'd2);
    do_cycle("drain"); do_cycle("drain");

    // JUMP -> two consecutive IF/ID flushes, no stalls
    drv(1, 0, 0, 0, 0, 0, 1, 0); do_cycle("jmpD");
    chk("jmp.flushD_pre", 8'(obs_fd), 8'd0);
    idle();                      do_cycle("jmpF1");
    chk("jmp.flushD_1", 8'(obs_fd), 8'd1);
    chk("jmp.stallF_1", 8'(obs_sf), 8'd0);
    do_cycle("jmpF2");
    chk("jmp.flushD_2", 8'(obs_fd), 8'd1);
    do_cycle("jmpEnd");
    chk("jmp.flushD_end", 8'(obs_fd), 8'd0);
    do_cycle("drain"); do_cycle("drain");

    // LOAD r2 ; JUMP using r2 -> stall first (flush suppressed), then flushes
    drv(1, 0, 0, 2, 1, 1, 0, 0); do_cycle("ljA");
    drv(1, 2, 0, 0, 0, 0, 1, 1); do_cycle("ljHit");
    chk("lj.stallD", 8'(obs_sd), 8'd1);
    chk("lj.flushD_blocked", 8'(obs_fd), 8'd0);
    do_cycle("ljRel");
    chk("lj.stallD_rel", 8'(obs_sd), 8'd0);
    idle();                      do_cycle("ljF1");
    chk("lj.flushD_1", 8'(obs_fd), 8'd1);
    do_cycle("ljF2");
    chk("lj.flushD_2", 8'(obs_fd), 8'd1);
    do_cycle("ljEnd");
    chk("lj.flushD_end", 8'(obs_fd), 8'd0);
    do_cycle("drain"); do_cycle("drain");

    // Reset while flushing with two cycles still owed
    drv(1, 0, 0, 0, 0, 0, 1, 0); do_cycle("rjD");
    idle();
    reset = 1'b1;                do_cycle("rjRst");
    reset = 1'b0;                do_cycle("rjAfter");
    chk("rj.flushD", 8'(obs_fd), 8'd0);
    chk("rj.stallF", 8'(obs_sf), 8'd0);
    do_cycle("rjAfter2");
    chk("rj.flushD_2", 8'(obs_fd), 8'd0);

    // Random decode traffic; a stalled instruction is held in D
    for (int n = 0; n < 800; n++) begin
      reset = ((n % 200) == 199);
      if (!exp_stall) begin
        if (flush_left > 0) idle();
        else begin
          bit v, j;
          v = ($urandom_range(0, 3) != 0);
          j = v && ($urandom_range(0, 7) == 0);
          drv(v, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), j,
              j && ($urandom_range(0, 1) == 1));
        end
      end
      do_cycle("rand");
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
